exu_wbck: RTL and testbench

- Write-back stage directly downstream of the ALU commit path.
- Arbitrates result beats from the ALU (single-cycle) and the LSU (long-latency) into a single register-file write port.
- Holds a 1-entry LSU skid buffer and a starvation counter so the ALU is never blocked indefinitely.
- Drives the regfile write enable, index and data from registered outputs.

---
 rtl/exu_wbck.sv | 82 ++++++++
 tb/tb_exu_wbck.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wbck.sv
// exu_wbck: arbitrates ALU and LSU result beats into one registered regfile write port,
// with a one-entry LSU skid buffer and an ALU starvation guard.
module exu_wbck #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               lsu_wbck_i_valid,
  output logic               lsu_wbck_i_ready,
  input  logic [XLEN-1:0]    lsu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] lsu_wbck_i_rdidx,
  input  logic               lsu_wbck_i_err,
  output logic               rf_wbck_o_ena,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic               wbck_err_o
);
  localparam logic [3:0] W_MAX = 4'(STARVE_MAX);
  logic               r_skid_full;
  logic               r_skid_err;
  logic [XLEN-1:0]    r_skid_wdat;
  logic [RFIDX_W-1:0] r_skid_rdidx;
  logic [3:0]         r_starve_cnt;
  logic               w_force_alu;
  logic               w_grant_alu;
  logic               w_grant_skid;
  logic               w_grant_lsu;
  logic               w_skid_fill;
  logic               w_vld;
  logic               w_err;
  logic [XLEN-1:0]    w_wdat;
  logic [RFIDX_W-1:0] w_rdidx;
  always_comb begin
    w_force_alu      = alu_wbck_i_valid && (r_starve_cnt == W_MAX);
    w_grant_alu      = w_force_alu || (!r_skid_full && !lsu_wbck_i_valid && alu_wbck_i_valid);
    w_grant_skid     = !w_force_alu && r_skid_full;
    w_grant_lsu      = !w_force_alu && !r_skid_full && lsu_wbck_i_valid;
    w_skid_fill      = w_force_alu && !r_skid_full && lsu_wbck_i_valid;
    w_vld            = w_grant_alu || w_grant_skid || w_grant_lsu;
    w_rdidx          = w_grant_alu ? alu_wbck_i_rdidx : r_skid_full ? r_skid_rdidx : lsu_wbck_i_rdidx;
    w_wdat           = w_grant_alu ? alu_wbck_i_wdat : r_skid_full ? r_skid_wdat : lsu_wbck_i_wdat;
    w_err            = w_grant_alu ? 1'b0 : r_skid_full ? r_skid_err : lsu_wbck_i_err;
    alu_wbck_i_ready = w_grant_alu;
    lsu_wbck_i_ready = !r_skid_full;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_full     <= 1'b0;
      r_skid_err      <= 1'b0;
      r_skid_wdat     <= '0;
      r_skid_rdidx    <= '0;
      r_starve_cnt    <= '0;
      rf_wbck_o_ena   <= 1'b0;
      rf_wbck_o_rdidx <= '0;
      rf_wbck_o_wdat  <= '0;
      wbck_err_o      <= 1'b0;
    end else begin
      if (w_skid_fill) begin
        r_skid_full  <= 1'b1;
        r_skid_err   <= lsu_wbck_i_err;
        r_skid_wdat  <= lsu_wbck_i_wdat;
        r_skid_rdidx <= lsu_wbck_i_rdidx;
      end else if (w_grant_skid) begin
        r_skid_full <= 1'b0;
      end
      r_starve_cnt  <= w_grant_alu ? 4'd0 :
                       (alu_wbck_i_valid && r_starve_cnt != W_MAX) ? r_starve_cnt + 4'd1 : r_starve_cnt;
      rf_wbck_o_ena <= w_vld && (w_rdidx != '0) && !w_err;
      wbck_err_o    <= w_vld && w_err;
      if (w_vld) begin
        rf_wbck_o_rdidx <= w_rdidx;
        rf_wbck_o_wdat  <= w_wdat;
      end
    end
  end
endmodule

// File: tb/tb_exu_wbck.sv
// tb_exu_wbck: directed scenario tasks for the exu_wbck write-back arbiter.
module tb_exu_wbck;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [31:0] alu_wdat = '0;
  logic [4:0]  alu_rdidx = '0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic [31:0] lsu_wdat = '0;
  logic [4:0]  lsu_rdidx = '0;
  logic        lsu_err = 1'b0;
  logic        rf_ena, wbck_err;
  logic [4:0]  rf_rdidx;
  logic [31:0] rf_wdat;
  logic        s_alu_rdy, s_lsu_rdy;
  int          checks = 0, errors = 0;

  exu_wbck #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(alu_valid), .alu_wbck_i_ready(alu_ready),
    .alu_wbck_i_wdat(alu_wdat), .alu_wbck_i_rdidx(alu_rdidx),
    .lsu_wbck_i_valid(lsu_valid), .lsu_wbck_i_ready(lsu_ready),
    .lsu_wbck_i_wdat(lsu_wdat), .lsu_wbck_i_rdidx(lsu_rdidx), .lsu_wbck_i_err(lsu_err),
    .rf_wbck_o_ena(rf_ena), .rf_wbck_o_rdidx(rf_rdidx), .rf_wbck_o_wdat(rf_wdat),
    .wbck_err_o(wbck_err)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge: drives one cycle of inputs,
  // samples the ready outputs mid-cycle, returns 1 unit after the next edge.
  task automatic cyc(input logic av, input logic [4:0] aidx, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lidx, input logic [31:0] ldat, input logic lerr);
    alu_valid = av; alu_rdidx = aidx; alu_wdat = adat;
    lsu_valid = lv; lsu_rdidx = lidx; lsu_wdat = ldat; lsu_err = lerr;
    #3;
    s_alu_rdy = alu_ready;
    s_lsu_rdy = lsu_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rf_ena !== 1'b0 || rf_rdidx !== 5'd0 || rf_wdat !== 32'd0 || wbck_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ena=%b idx=%0d dat=%h err=%b, required all 0", rf_ena, rf_rdidx, rf_wdat, wbck_err);
    end
    checks++;
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: lsu=%b alu=%b, required lsu=1 alu=0", lsu_ready, alu_ready);
    end
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf_ena !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: ena=%b, required 0", rf_ena);
    end
  endtask

  task automatic test_alu_single;
    cyc(1, 5'd5, 32'h1234, 0, 0, 0, 0);
    checks++;
    if (s_alu_rdy !== 1'b1) begin
      errors++; $display("FAIL alu_single_ready: got %b, required 1", s_alu_rdy);
    end
    checks++;
    if (rf_ena !== 1'b1 || rf_rdidx !== 5'd5 || rf_wdat !== 32'h1234 || wbck_err !== 1'b0) begin
      errors++; $display("FAIL alu_single_write: ena=%b idx=%0d dat=%h err=%b, required 1/5/00001234/0", rf_ena, rf_rdidx, rf_wdat, wbck_err);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf_ena !== 1'b0 || rf_rdidx !== 5'd5 || rf_wdat !== 32'h1234) begin
      errors++; $display("FAIL alu_single_after: ena=%b idx=%0d dat=%h, required 0 with idx/dat held", rf_ena, rf_rdidx, rf_wdat);
    end
  endtask

  task automatic test_starvation;
    int exp_src [11] = '{0, 1, 2, 3, -1, 4, 5, 6, 7, -1, 8};
    bit exp_ar  [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    bit exp_lr  [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n = 0;
    for (int c = 0; c < 11; c++) begin
      logic v;
      logic [4:0] ei;
      logic [31:0] ed;
      v = (c < 10);
      cyc(v, 5'd3, 32'hA1, v, 5'(8 + n), 32'hB000 + n, 0);
      if (v && s_lsu_rdy) n++;
      checks++;
      if (s_alu_rdy !== exp_ar[c] || s_lsu_rdy !== exp_lr[c]) begin
        errors++; $display("FAIL starve_ready c%0d: alu=%b lsu=%b, required alu=%b lsu=%b", c, s_alu_rdy, s_lsu_rdy, exp_ar[c], exp_lr[c]);
      end
      ei = exp_src[c] < 0 ? 5'd3 : 5'(8 + exp_src[c]);
      ed = exp_src[c] < 0 ? 32'hA1 : 32'hB000 + exp_src[c];
      checks++;
      if (rf_ena !== 1'b1 || rf_rdidx !== ei || rf_wdat !== ed) begin
        errors++; $display("FAIL starve_write c%0d: ena=%b idx=%0d dat=%h, required 1/%0d/%h", c, rf_ena, rf_rdidx, rf_wdat, ei, ed);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf_ena !== 1'b0 || s_lsu_rdy !== 1'b1) begin
      errors++; $display("FAIL starve_drain: ena=%b lsu_rdy=%b, required 0/1", rf_ena, s_lsu_rdy);
    end
  endtask

  task automatic test_x0;
    cyc(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0);
    checks++;
    if (s_lsu_rdy !== 1'b1) begin
      errors++; $display("FAIL x0_ready: got %b, required 1", s_lsu_rdy);
    end
    checks++;
    if (rf_ena !== 1'b0 || wbck_err !== 1'b0) begin
      errors++; $display("FAIL x0_write: ena=%b err=%b, required 0/0", rf_ena, wbck_err);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_err_skid;
    for (int k = 0; k < 4; k++) cyc(1, 5'd3, 32'hA2, 1, 5'(20 + k), 32'hD000 + k, 0);
    cyc(1, 5'd3, 32'hA2, 1, 5'd7, 32'hDEAD, 1);
    checks++;
    if (s_alu_rdy !== 1'b1 || s_lsu_rdy !== 1'b1) begin
      errors++; $display("FAIL err_force_ready: alu=%b lsu=%b, required 1/1", s_alu_rdy, s_lsu_rdy);
    end
    checks++;
    if (rf_ena !== 1'b1 || rf_rdidx !== 5'd3 || wbck_err !== 1'b0) begin
      errors++; $display("FAIL err_force_write: ena=%b idx=%0d err=%b, required 1/3/0", rf_ena, rf_rdidx, wbck_err);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (s_lsu_rdy !== 1'b0) begin
      errors++; $display("FAIL err_skid_ready: lsu=%b, required 0", s_lsu_rdy);
    end
    checks++;
    if (rf_ena !== 1'b0 || wbck_err !== 1'b1) begin
      errors++; $display("FAIL err_retire: ena=%b err=%b, required 0/1", rf_ena, wbck_err);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf_ena !== 1'b0 || wbck_err !== 1'b0 || s_lsu_rdy !== 1'b1) begin
      errors++; $display("FAIL err_pulse_end: ena=%b err=%b lsu=%b, required 0/0/1", rf_ena, wbck_err, s_lsu_rdy);
    end
  endtask

  task automatic test_back_to_back;
    int low = 0;
    for (int k = 0; k < 4; k++) cyc(1, 5'd3, 32'hA3, 1, 5'(20 + k), 32'hC000 + k, 0);
    cyc(1, 5'd3, 32'hA3, 1, 5'd1, 32'hAAAA, 0);
    low += !s_lsu_rdy;
    checks++;
    if (s_alu_rdy !== 1'b1 || rf_ena !== 1'b1 || rf_rdidx !== 5'd3 || rf_wdat !== 32'hA3) begin
      errors++; $display("FAIL b2b_alu: rdy=%b ena=%b idx=%0d dat=%h, required 1/1/3/000000a3", s_alu_rdy, rf_ena, rf_rdidx, rf_wdat);
    end
    cyc(0, 0, 0, 1, 5'd2, 32'hBBBB, 0);
    low += !s_lsu_rdy;
    checks++;
    if (s_lsu_rdy !== 1'b0 || rf_ena !== 1'b1 || rf_rdidx !== 5'd1 || rf_wdat !== 32'hAAAA) begin
      errors++; $display("FAIL b2b_A: lsu=%b ena=%b idx=%0d dat=%h, required 0/1/1/0000aaaa", s_lsu_rdy, rf_ena, rf_rdidx, rf_wdat);
    end
    cyc(0, 0, 0, 1, 5'd2, 32'hBBBB, 0);
    low += !s_lsu_rdy;
    checks++;
    if (s_lsu_rdy !== 1'b1 || rf_ena !== 1'b1 || rf_rdidx !== 5'd2 || rf_wdat !== 32'hBBBB) begin
      errors++; $display("FAIL b2b_B: lsu=%b ena=%b idx=%0d dat=%h, required 1/1/2/0000bbbb", s_lsu_rdy, rf_ena, rf_rdidx, rf_wdat);
    end
    cyc(0, 0, 0, 1, 5'd4, 32'hCCCC, 0);
    low += !s_lsu_rdy;
    checks++;
    if (s_lsu_rdy !== 1'b1 || rf_ena !== 1'b1 || rf_rdidx !== 5'd4 || rf_wdat !== 32'hCCCC) begin
      errors++; $display("FAIL b2b_C: lsu=%b ena=%b idx=%0d dat=%h, required 1/1/4/0000cccc", s_lsu_rdy, rf_ena, rf_rdidx, rf_wdat);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf_ena !== 1'b0 || low != 1) begin
      errors++; $display("FAIL b2b_end: ena=%b ready_low_cycles=%0d, required 0/1", rf_ena, low);
    end
  endtask

  task automatic test_midstream_reset;
    for (int k = 0; k < 4; k++) cyc(1, 5'd3, 32'hA4, 1, 5'(20 + k), 32'hE000 + k, 0);
    cyc(1, 5'd3, 32'hA4, 1, 5'd9, 32'h9999, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checks++;
    if (rf_ena !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL mid_setup: ena=%b lsu_rdy=%b, required 1/0", rf_ena, lsu_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rf_ena !== 1'b0 || rf_rdidx !== 5'd0 || rf_wdat !== 32'd0 || wbck_err !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: ena=%b idx=%0d dat=%h err=%b lsu=%b, required 0/0/0/0/1", rf_ena, rf_rdidx, rf_wdat, wbck_err, lsu_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (rf_ena !== 1'b0 || wbck_err !== 1'b0 || s_lsu_rdy !== 1'b1) begin
        errors++; $display("FAIL mid_release c%0d: ena=%b err=%b lsu=%b, required 0/0/1", k, rf_ena, wbck_err, s_lsu_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_starvation();
    test_x0();
    test_err_skid();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
